sram_mem_controller: RTL and testbench

- Multi-cycle controller that sequences MEM-stage data accesses onto the external 16-bit SRAM.
- Driven by the mem_r_en/mem_w_en decoded by the control unit for LDR and STR.
- Splits each 32-bit word access into two 16-bit SRAM phases and holds ready low for the duration, so the pipeline freezes until the access completes.

---
 rtl/mem_ctrl_pkg.sv | 23 ++
 rtl/sram_phase_counter.sv | 27 ++
 rtl/sram_mem_controller.sv | 110 +++++++++++
 tb/tb_sram_mem_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the SRAM-backed memory controllers: state encoding,
// default address map / timing, SRAM bus widths and the word-index helper.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] DEF_BASE_ADDR     = 32'd1024;
    localparam int          DEF_ACCESS_CYCLES = 3;
    localparam int          ADDR_W            = 18;
    localparam int          DQ_W              = 16;

    // Byte address -> 32-bit word index; unmapped high bits and byte offset drop out.
    function automatic logic [ADDR_W-2:0] word_index(input logic [31:0] address,
                                                     input logic [31:0] base);
        return (ADDR_W-1)'((address - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Counts the clocks of one SRAM phase, wrapping to 0 after ACCESS_CYCLES-1.
// last flags the final clock of the phase.
module sram_phase_counter #(
    parameter int  ACCESS_CYCLES = 3,
    localparam int CW            = $clog2(ACCESS_CYCLES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          last
);

    assign last = (count == CW'(ACCESS_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage data controller: each 32-bit LDR/STR becomes two 16-bit SRAM
// phases (low half, then high half) while ready holds the pipeline frozen.
module sram_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR,
    parameter int          ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_we_n,
    output logic [DQ_W-1:0]   sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DQ_W-1:0]   sram_dq_in,
    output logic [1:0]        dbg_state
);

    localparam int CW = $clog2(ACCESS_CYCLES);

    state_t            state;
    logic              is_write;
    logic [ADDR_W-2:0] idx;
    logic [31:0]       wdata;
    logic [CW-1:0]     count;
    logic              last;
    logic              req;
    logic              we_next;

    // Handshake: the MEM stage holds rd_en/wr_en (and address/data) until it
    // sees ready high; ready high with a request pending means that request
    // has just completed (DONE), never that a new one was accepted.
    assign req       = rd_en | wr_en;
    assign ready     = (state == DONE) || (state == IDLE && !req);
    assign dbg_state = state;

    // Strobe stays low up to the second-to-last clock so address/data are held on the last.
    assign we_next = is_write && (int'(count) < ACCESS_CYCLES - 2);

    sram_phase_counter #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_phase_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE || state == DONE),
        .en    (state == LO || state == HI),
        .count (count),
        .last  (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            is_write    <= 1'b0;
            idx         <= '0;
            wdata       <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state       <= LO;
                        is_write    <= wr_en;
                        idx         <= word_index(address, BASE_ADDR);
                        wdata       <= write_data;
                        sram_addr   <= {word_index(address, BASE_ADDR), 1'b0};
                        sram_dq_out <= write_data[15:0];
                        sram_dq_oe  <= wr_en;
                        sram_we_n   <= !wr_en;
                    end
                end
                LO: begin
                    if (last) begin
                        state       <= HI;
                        sram_addr   <= {idx, 1'b1};
                        sram_dq_out <= wdata[31:16];
                        sram_dq_oe  <= is_write;
                        sram_we_n   <= !is_write;
                        if (!is_write) read_data[15:0] <= sram_dq_in;
                    end else begin
                        sram_we_n <= !we_next;
                    end
                end
                HI: begin
                    if (last) begin
                        state      <= DONE;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                        if (!is_write) read_data[31:16] <= sram_dq_in;
                    end else begin
                        sram_we_n <= !we_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller with a small asynchronous-read SRAM
// model; each scenario task checks its own hand-computed expectations.
module tb_sram_mem_controller;

    localparam int ACC = 3;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic [1:0]  dbg_state;

    logic [15:0] mem [0:15];

    int n_checks;
    int n_fail;

    // per-access observations gathered by run_access
    int          done_cyc;
    int          low_cnt;
    int          we_even;
    int          we_odd;
    logic        ready0;
    logic        oe_any;
    logic [17:0] addr_lo;
    logic [17:0] addr_hi;
    logic [1:0]  st_c1;
    logic [31:0] rd_at_done;

    sram_mem_controller #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(ACC)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_we_n   (sram_we_n),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .dbg_state   (dbg_state)
    );

    // clock / SRAM model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_dq_in = mem[sram_addr[3:0]];

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr[3:0]] <= sram_dq_out;
    end

    // driver: present a request, hold it until ready, observe each cycle
    task automatic run_access(input logic w, input logic r,
                              input logic [31:0] a, input logic [31:0] d);
        wr_en = w; rd_en = r; address = a; write_data = d;
        done_cyc = -1; low_cnt = 0; we_even = 0; we_odd = 0;
        oe_any = 1'b0; ready0 = 1'b1; addr_lo = '1; addr_hi = '1;
        st_c1 = 2'd0; rd_at_done = '0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            if (c == 0) ready0 = ready;
            if (c == 1) begin
                st_c1 = dbg_state; addr_lo = sram_addr;
                address = a ^ 32'h40; write_data = ~d;
            end
            if (c == ACC + 1) addr_hi = sram_addr;
            if (c > 0 && ready) begin
                done_cyc = c; rd_at_done = read_data;
                break;
            end
            if (c > 0) begin
                low_cnt++;
                if (sram_dq_oe) oe_any = 1'b1;
                if (!sram_we_n) begin
                    if (sram_addr[0]) we_odd++;
                    else we_even++;
                end
            end
        end
        n_checks++;
        if (done_cyc < 0) begin
            n_fail++;
            $display("FAIL access_timeout: ready never rose, addr=%h", a);
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_checks++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL reset_read_data: got %h want 0", read_data); end
        n_checks++; if (sram_addr !== 18'h0) begin n_fail++; $display("FAIL reset_sram_addr: got %h want 0", sram_addr); end
        n_checks++; if ({sram_we_n, sram_dq_oe, sram_dq_out} !== {1'b1, 1'b0, 16'h0}) begin
            n_fail++; $display("FAIL reset_sram_ctl: we_n=%b oe=%b dq=%h want 1 0 0000", sram_we_n, sram_dq_oe, sram_dq_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        run_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        n_checks++; if (ready0 !== 1'b0) begin n_fail++; $display("FAIL wr_ready_cycle0: got %b want 0", ready0); end
        n_checks++; if (done_cyc != 7) begin n_fail++; $display("FAIL wr_done_cycle: got %0d want 7", done_cyc); end
        n_checks++; if (low_cnt != 6) begin n_fail++; $display("FAIL wr_low_cycles: got %0d want 6", low_cnt); end
        n_checks++; if (we_even != 2 || we_odd != 2) begin n_fail++; $display("FAIL wr_we_pulses: got lo=%0d hi=%0d want 2 2", we_even, we_odd); end
        n_checks++; if (mem[0] !== 16'hBEEF) begin n_fail++; $display("FAIL wr_word0: got %h want beef", mem[0]); end
        n_checks++; if (mem[1] !== 16'hDEAD) begin n_fail++; $display("FAIL wr_word1: got %h want dead", mem[1]); end
    endtask

    task automatic test_read();
        run_access(1'b0, 1'b1, 32'd1024, 32'h0);
        n_checks++; if (addr_lo !== 18'd0 || addr_hi !== 18'd1) begin n_fail++; $display("FAIL rd_addr_seq: got %0d,%0d want 0,1", addr_lo, addr_hi); end
        n_checks++; if (oe_any !== 1'b0) begin n_fail++; $display("FAIL rd_oe: got %b want 0", oe_any); end
        n_checks++; if (we_even + we_odd != 0) begin n_fail++; $display("FAIL rd_we: got %0d strobes want 0", we_even + we_odd); end
        n_checks++; if (done_cyc != 7) begin n_fail++; $display("FAIL rd_done_cycle: got %0d want 7", done_cyc); end
        n_checks++; if (rd_at_done !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", rd_at_done); end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_addr !== 18'd1) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: ready=%b we_n=%b addr=%0d want 1 1 1", i, ready, sram_we_n, sram_addr);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_both_enables();
        run_access(1'b1, 1'b1, 32'd1032, 32'h12345678);
        n_checks++; if (addr_lo !== 18'd4 || addr_hi !== 18'd5) begin n_fail++; $display("FAIL both_addr_seq: got %0d,%0d want 4,5", addr_lo, addr_hi); end
        n_checks++; if (mem[4] !== 16'h5678 || mem[5] !== 16'h1234) begin n_fail++; $display("FAIL both_mem: got %h %h want 5678 1234", mem[4], mem[5]); end
        n_checks++; if (we_even != 2 || we_odd != 2) begin n_fail++; $display("FAIL both_we_pulses: got %0d %0d want 2 2", we_even, we_odd); end
        n_checks++; if (rd_at_done !== 32'hDEADBEEF) begin n_fail++; $display("FAIL both_read_data: got %h want deadbeef", rd_at_done); end
    endtask

    task automatic test_reset_mid_access();
        rd_en = 1'b1; address = 32'd1024;
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL mid_pre_state: got %0d want 2", dbg_state); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (dbg_state !== 2'd0 || read_data !== 32'h0 || sram_addr !== 18'h0) begin
            n_fail++; $display("FAIL mid_reset_regs: state=%0d rd=%h addr=%h want 0 0 0", dbg_state, read_data, sram_addr);
        end
        n_checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_dq_out !== 16'h0) begin
            n_fail++; $display("FAIL mid_reset_ctl: we_n=%b oe=%b dq=%h want 1 0 0000", sram_we_n, sram_dq_oe, sram_dq_out);
        end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_req_held: got %b want 0", ready); end
        rd_en = 1'b0;
        #1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_req_dropped: got %b want 1", ready); end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        run_access(1'b0, 1'b1, 32'd1032, 32'h0);
        n_checks++; if (rd_at_done !== 32'h12345678) begin n_fail++; $display("FAIL mid_post_read: got %h want 12345678", rd_at_done); end
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 1'b0, 32'd1028, 32'hA5A55A5A);
        n_checks++; if (done_cyc != 7) begin n_fail++; $display("FAIL b2b_wr_done: got %0d want 7", done_cyc); end
        run_access(1'b0, 1'b1, 32'd1028, 32'h0);
        n_checks++; if (st_c1 !== 2'd1) begin n_fail++; $display("FAIL b2b_rd_start: state %0d want 1 one cycle after request", st_c1); end
        n_checks++; if (done_cyc != 7) begin n_fail++; $display("FAIL b2b_rd_done: got %0d want 7", done_cyc); end
        n_checks++; if (mem[2] !== 16'h5A5A || mem[3] !== 16'hA5A5) begin n_fail++; $display("FAIL b2b_mem: got %h %h want 5a5a a5a5", mem[2], mem[3]); end
        n_checks++; if (rd_at_done !== 32'hA5A55A5A) begin n_fail++; $display("FAIL b2b_read_data: got %h want a5a55a5a", rd_at_done); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        test_reset();
        test_write();
        test_read();
        test_idle();
        test_both_enables();
        test_reset_mid_access();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
